// File: rtl/tcp_payload_packer.sv
// Packs in_bits TCP payload beats into data_bits buffer words with segment bookkeeping.
// Optional build macro TCP_PACKER_BSWAP_EN byte-reverses each beat before lane placement.
module tcp_payload_packer #(
  parameter int data_bits    = 512,
  parameter int in_bits      = 64,
  parameter int address_bits = 10,
  parameter int mem_depth    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [in_bits-1:0]      s_data,
  input  logic [in_bits/8-1:0]    s_keep,
  input  logic                    s_last,
  input  logic                    rd_release,
  output logic                    fifo_wr_en,
  output logic [data_bits-1:0]    fifo_rxdata,
  output logic [address_bits-1:0] address_input,
  output logic                    seg_done,
  output logic [15:0]             seg_len,
  output logic [address_bits-1:0] seg_start_addr
);

  localparam int LANES  = data_bits / in_bits;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BYTES  = in_bits / 8;
  localparam int OCC_W  = $clog2(mem_depth + 1);

  typedef enum logic {IDLE, PACK} state_t;

  state_t                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [data_bits-1:0]    word_q, word_d;
  logic [address_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    fifo_wr_en_q, fifo_wr_en_d;
  logic [data_bits-1:0]    fifo_rxdata_q, fifo_rxdata_d;
  logic [address_bits-1:0] address_input_q, address_input_d;
  logic                    seg_done_q, seg_done_d;
  logic [15:0]             seg_len_q, seg_len_d;
  logic [address_bits-1:0] seg_start_addr_q, seg_start_addr_d;
  logic [15:0]             len_acc_q, len_acc_d;
  logic [address_bits-1:0] start_acc_q, start_acc_d;

  function automatic logic [in_bits-1:0] mask_beat(input logic [in_bits-1:0] d,
                                                   input logic [BYTES-1:0]   keep);
    logic [in_bits-1:0] r;
    r = d;
    for (int b = 0; b < BYTES; b++) begin
      if (!keep[b]) r[b*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [15:0] popcount(input logic [BYTES-1:0] keep);
    logic [15:0] cnt;
    cnt = '0;
    for (int b = 0; b < BYTES; b++) begin
      cnt = cnt + 16'(keep[b]);
    end
    return cnt;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef TCP_PACKER_BSWAP_EN
  function automatic logic [in_bits-1:0] order_beat(input logic [in_bits-1:0] d);
    logic [in_bits-1:0] r;
    for (int b = 0; b < BYTES; b++) begin
      r[b*8 +: 8] = d[(BYTES-1-b)*8 +: 8];
    end
    return r;
  endfunction
`else
  function automatic logic [in_bits-1:0] order_beat(input logic [in_bits-1:0] d);
    return d;
  endfunction
`endif

  logic                    accept;
  logic                    complete;
  logic                    release_eff;
  logic                    first_beat;
  logic [in_bits-1:0]      beat_placed;
  logic [data_bits-1:0]    word_fill;
  logic [15:0]             len_base;
  logic [address_bits-1:0] start_cur;

  assign s_ready = !reset && (occ_q < OCC_W'(mem_depth));

  always_comb begin
    state_d          = state_q;
    lane_d           = lane_q;
    word_d           = word_q;
    wr_ptr_d         = wr_ptr_q;
    occ_d            = occ_q;
    fifo_wr_en_d     = 1'b0;
    fifo_rxdata_d    = fifo_rxdata_q;
    address_input_d  = address_input_q;
    seg_done_d       = 1'b0;
    seg_len_d        = seg_len_q;
    seg_start_addr_d = seg_start_addr_q;
    len_acc_d        = len_acc_q;
    start_acc_d      = start_acc_q;

    accept      = s_valid && s_ready;
    complete    = accept && (s_last || (lane_q == LANE_W'(LANES - 1)));
    release_eff = rd_release && (occ_q != '0);
    first_beat  = (state_q == IDLE);

    // Keep masking uses the wire byte order, so mask before any reordering.
    beat_placed = order_beat(s_last ? mask_beat(s_data, s_keep) : s_data);

    // Lane 0 starts a fresh word; stale upper lanes are never carried over.
    word_fill = (lane_q == '0) ? '0 : word_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == LANE_W'(l)) word_fill[l*in_bits +: in_bits] = beat_placed;
    end

    len_base  = first_beat ? 16'h0000 : len_acc_q;
    start_cur = first_beat ? wr_ptr_q : start_acc_q;

    if (accept) begin
      word_d      = word_fill;
      lane_d      = complete ? '0 : lane_q + LANE_W'(1);
      start_acc_d = start_cur;
      if (s_last) begin
        state_d          = IDLE;
        seg_done_d       = 1'b1;
        seg_len_d        = sat_add16(len_base, popcount(s_keep));
        seg_start_addr_d = start_cur;
        len_acc_d        = '0;
      end else begin
        state_d   = PACK;
        len_acc_d = sat_add16(len_base, 16'(BYTES));
      end
      if (complete) begin
        fifo_wr_en_d    = 1'b1;
        fifo_rxdata_d   = word_fill;
        address_input_d = wr_ptr_q;
        wr_ptr_d        = (wr_ptr_q == address_bits'(mem_depth - 1)) ? '0
                                                                     : wr_ptr_q + address_bits'(1);
      end
    end

    if (complete && !release_eff) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (release_eff && !complete) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      lane_q           <= '0;
      wr_ptr_q         <= '0;
      occ_q            <= '0;
      fifo_wr_en_q     <= 1'b0;
      fifo_rxdata_q    <= '0;
      address_input_q  <= '0;
      seg_done_q       <= 1'b0;
      seg_len_q        <= '0;
      seg_start_addr_q <= '0;
      len_acc_q        <= '0;
      start_acc_q      <= '0;
    end else begin
      state_q          <= state_d;
      lane_q           <= lane_d;
      wr_ptr_q         <= wr_ptr_d;
      occ_q            <= occ_d;
      fifo_wr_en_q     <= fifo_wr_en_d;
      fifo_rxdata_q    <= fifo_rxdata_d;
      address_input_q  <= address_input_d;
      seg_done_q       <= seg_done_d;
      seg_len_q        <= seg_len_d;
      seg_start_addr_q <= seg_start_addr_d;
      len_acc_q        <= len_acc_d;
      start_acc_q      <= start_acc_d;
    end
  end

  // The partial-word accumulator needs no reset: lane 0 always overwrites it.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign fifo_wr_en     = fifo_wr_en_q;
  assign fifo_rxdata    = fifo_rxdata_q;
  assign address_input  = address_input_q;
  assign seg_done       = seg_done_q;
  assign seg_len        = seg_len_q;
  assign seg_start_addr = seg_start_addr_q;

endmodule

// File: tb/tb_tcp_payload_packer.sv
// Scoreboard bench for tcp_payload_packer: directed stimulus pushes expected writes/segments.
module tb_tcp_payload_packer;

  localparam int DW = 512;
  localparam int IW = 64;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [IW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_last = 1'b0;
  logic          rd_release = 1'b0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_rxdata;
  logic [AW-1:0] address_input;
  logic          seg_done;
  logic [15:0]   seg_len;
  logic [AW-1:0] seg_start_addr;

  tcp_payload_packer #(
    .data_bits(DW), .in_bits(IW), .address_bits(AW), .mem_depth(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .rd_release(rd_release),
    .fifo_wr_en(fifo_wr_en), .fifo_rxdata(fifo_rxdata), .address_input(address_input),
    .seg_done(seg_done), .seg_len(seg_len), .seg_start_addr(seg_start_addr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [15:0] len; logic [AW-1:0] start; } seg_t;
  wr_t  wr_q[$];
  seg_t seg_q[$];
  wr_t  mon_wr;
  seg_t mon_seg;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] xb(input logic [63:0] d);
`ifdef TCP_PACKER_BSWAP_EN
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = d[(7-b)*8 +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: every presented write / segment completion is matched against the queues.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%0d", address_input);
      end else begin
        mon_wr = wr_q.pop_front();
        chk("wr_addr", 64'(address_input), 64'(mon_wr.addr));
        checks++;
        if (fifo_rxdata !== mon_wr.data) begin
          errors++;
          $display("FAIL wr_data addr=%0d got=%h expected=%h", mon_wr.addr, fifo_rxdata, mon_wr.data);
        end
      end
    end
    if (seg_done) begin
      if (seg_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_seg_done len=%0d", seg_len);
      end else begin
        mon_seg = seg_q.pop_front();
        chk("seg_len", 64'(seg_len), 64'(mon_seg.len));
        chk("seg_start_addr", 64'(seg_start_addr), 64'(mon_seg.start));
        chk("seg_done_with_wr", 64'(fifo_wr_en), 64'd1);
      end
    end
  end

  task automatic push_wr(input int addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = AW'(addr);
    e.data = data;
    wr_q.push_back(e);
  endtask

  task automatic push_seg(input int len, input int start);
    seg_t e;
    e.len = 16'(len);
    e.start = AW'(start);
    seg_q.push_back(e);
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic rel);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; rd_release = rel;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout s_ready=%0b required=1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; s_keep = '0; rd_release = 1'b0;
  endtask

  task automatic pulse_release();
    @(negedge clk);
    rd_release = 1'b1;
    @(posedge clk);
    #1;
    rd_release = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wr_q.size() != 0 || seg_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("seg_queue_empty", 64'(seg_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_in_reset", 64'(s_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_rxdata_zero", 64'(fifo_rxdata == '0), 64'd1);
    chk("rst_address", 64'(address_input), 64'd0);
    chk("rst_seg_done", 64'(seg_done), 64'd0);
    chk("rst_seg_len", 64'(seg_len), 64'd0);
    chk("rst_seg_start", 64'(seg_start_addr), 64'd0);
    chk("ready_after_reset", 64'(s_ready), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [63:0]   b;

    do_reset();

    // Full 8-beat segment, lane k holds k+1.
    push_wr(0, {xb(64'h8), xb(64'h7), xb(64'h6), xb(64'h5),
                xb(64'h4), xb(64'h3), xb(64'h2), xb(64'h1)});
    push_seg(64, 0);
    for (int k = 1; k <= 8; k++) send(64'(k), 8'hFF, k == 8, 1'b0);

    // Back-to-back 3-beat segment with partial keep on the last beat.
    push_wr(1, {320'h0, xb(64'h0000000033333333), xb(64'h2222222222222222),
                xb(64'h1111111111111111)});
    push_seg(20, 1);
    send(64'h1111111111111111, 8'hFF, 1'b0, 1'b0);
    send(64'h2222222222222222, 8'hFF, 1'b0, 1'b0);
    send(64'h3333333333333333, 8'h0F, 1'b1, 1'b0);
    drain();

    // Reset in the middle of a segment discards it.
    for (int k = 0; k < 5; k++) send(64'hDEAD000000000000 | 64'(k), 8'hFF, 1'b0, 1'b0);
    do_reset();
    w = '0;
    for (int k = 0; k < 8; k++) w[k*64 +: 64] = xb(64'h5500000000000000 | 64'(k));
    push_wr(0, w);
    push_seg(64, 0);
    for (int k = 0; k < 8; k++) send(64'h5500000000000000 | 64'(k), 8'hFF, k == 7, 1'b0);
    drain();

    // Fill the whole buffer as one saturating segment.
    do_reset();
    push_seg(65535, 0);
    for (int wi = 0; wi < DEPTH; wi++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[k*64 +: 64] = xb({16'hA5A5, 16'(wi), 24'h0, 8'(k)});
      push_wr(wi, w);
      for (int k = 0; k < 8; k++) begin
        b = {16'hA5A5, 16'(wi), 24'h0, 8'(k)};
        send(b, 8'hFF, (wi == DEPTH - 1) && (k == 7), 1'b0);
      end
    end
    chk("ready_low_when_full", 64'(s_ready), 64'd0);
    drain();
    chk("ready_stays_low", 64'(s_ready), 64'd0);
    pulse_release();
    chk("ready_after_release", 64'(s_ready), 64'd1);
    push_wr(0, {448'h0, xb(64'h000000000000CAFE)});
    push_seg(8, 0);
    send(64'h000000000000CAFE, 8'hFF, 1'b1, 1'b0);
    chk("ready_low_full_again", 64'(s_ready), 64'd0);
    drain();

    // Release coincident with a completion at occupancy DEPTH-1.
    pulse_release();
    chk("ready_at_depth_m1", 64'(s_ready), 64'd1);
    push_wr(1, {448'h0, xb(64'h00000000BEEF0001)});
    push_seg(8, 1);
    send(64'h00000000BEEF0001, 8'hFF, 1'b1, 1'b1);
    chk("ready_coincident", 64'(s_ready), 64'd1);
    push_wr(2, {448'h0, xb(64'h00000000BEEF0002)});
    push_seg(8, 2);
    send(64'h00000000BEEF0002, 8'hFF, 1'b1, 1'b0);
    chk("ready_low_after_refill", 64'(s_ready), 64'd0);
    drain();

    // Release at zero occupancy is ignored; single-beat segment with byte order check.
    do_reset();
    pulse_release();
    chk("ready_release_at_zero", 64'(s_ready), 64'd1);
`ifdef TCP_PACKER_BSWAP_EN
    push_wr(0, {448'h0, 64'h0102030405060708});
`else
    push_wr(0, {448'h0, 64'h0807060504030201});
`endif
    push_seg(8, 0);
    send(64'h0807060504030201, 8'hFF, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
